round_clock_gen: RTL

- Single-clock sequencer that drives the clock and clear pins of a cascaded dual 4-bit ripple counter pair (8-bit round counter) in the SHA-256 datapath.
- On START it issues one clear pulse, then exactly ROUNDS count pulses, then flags DONE.
- It keeps a registered shadow copy of the count the external counter must hold, for comparison and debug.
- Wiring outside this block: CNT_CLK goes to the low counter's CLK input. CNT_CLR goes to both counters' clear inputs. The high counter is clocked from the low counter's Q[3].

---
 rtl/round_clock_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/round_clock_gen.sv
// Purpose : sequences the clock/clear pins of an external cascaded 2x4-bit ripple
//           round counter: one clear pulse, ROUNDS count pulses, then a DONE strobe.
// Latency : START sampled on edge 0 -> BUSY for 2+2*ROUNDS cycles, DONE the cycle after.
// Backpr. : HOLD freezes the current CNT_CLK level (never adds/drops an edge); START
//           is only accepted in IDLE and is otherwise dropped.
//
// Ports:
//   CLK      system clock, rising-edge
//   CLR      asynchronous active-low reset
//   START    run request (IDLE only)
//   HOLD     pause pulse generation while high
//   CNT_CLK  counter clock drive (counter advances on its falling edge)
//   CNT_CLR  counter clear drive, active-high, taken on a CNT_CLK falling edge
//   SHADOW   value the external counter is expected to hold
//   BUSY     high from the first CLR_HI cycle through the last PULSE_LO cycle
//   DONE     one-cycle completion strobe
module round_clock_gen #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic             HOLD,
    output logic             CNT_CLK,
    output logic             CNT_CLR,
    output logic [CNT_W-1:0] SHADOW,
    output logic             BUSY,
    output logic             DONE
);

    // SHADOW must never wrap inside a run: ROUNDS < 2^CNT_W, i.e. ROUNDS >> CNT_W == 0.
    generate
        if (ROUNDS < 1 || ROUNDS > 255 || (ROUNDS >> CNT_W) != 0) begin : g_bad_param
            $error("round_clock_gen: ROUNDS must be 1..255 and below 2**CNT_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_HI,
        S_CLR_LO,
        S_PULSE_HI,
        S_PULSE_LO,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] ROUNDS_CW = CNT_W'(ROUNDS);

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   rnd_q,     rnd_d;
    logic [CNT_W-1:0]   shadow_q,  shadow_d;
    logic               cnt_clk_q, cnt_clk_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        shadow_d  = shadow_q;
        cnt_clk_d = 1'b0;
        cnt_clr_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        // Next-state selection.
        unique case (state_q)
            S_IDLE:     if (START) state_d = S_CLR_HI;
            S_CLR_HI:   state_d = S_CLR_LO;   // HOLD deliberately ignored during clear
            S_CLR_LO:   state_d = S_PULSE_HI;
            S_PULSE_HI: if (!HOLD) state_d = S_PULSE_LO;
            S_PULSE_LO: begin
                if (!HOLD) begin
                    if (rnd_q == LAST_RND) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_PULSE_HI;
                        rnd_d   = rnd_q + 1'b1;
                    end
                end
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so that every output
        // is a flop aligned with state_q; nothing from an input reaches a pin
        // without a register in between.
        unique case (state_d)
            S_CLR_HI: begin
                cnt_clr_d = 1'b1;
                cnt_clk_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_CLR_LO: begin
                // Falling CNT_CLK with CNT_CLR high clears the external counter.
                cnt_clr_d = 1'b1;
                busy_d    = 1'b1;
                shadow_d  = '0;
                rnd_d     = '0;
            end
            S_PULSE_HI: begin
                // Clear drops on the rising edge; the counter only looks at
                // clear on a falling edge, so this is safe.
                cnt_clk_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_PULSE_LO: begin
                busy_d = 1'b1;
                // Count only on entry: a held PULSE_LO is still a single falling edge.
                if (state_q != S_PULSE_LO) shadow_d = shadow_q + 1'b1;
            end
            S_FINISH: begin
                done_d   = 1'b1;
                shadow_d = ROUNDS_CW;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= S_IDLE;
            rnd_q     <= '0;
            shadow_q  <= '0;
            cnt_clk_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            shadow_q  <= shadow_d;
            cnt_clk_q <= cnt_clk_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CNT_CLK = cnt_clk_q;
    assign CNT_CLR = cnt_clr_q;
    assign SHADOW  = shadow_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule
